// File: rtl/tank_pkg.sv
// Shared object-attribute types for the tank renderer: OAM entry layout, field
// offsets, tile defaults and the span test used by the line scanner.
package tank_pkg;

    localparam int TILE_W_DEF = 32;
    localparam int TILE_H_DEF = 32;

    localparam logic [1:0] OBJ_TYPE_PLAYER = 2'b00;
    localparam logic [1:0] OBJ_TYPE_OPPO   = 2'b01;

    localparam int OFS_COL   = 0;
    localparam int OFS_ROW   = 3;
    localparam int OFS_DIR   = 6;
    localparam int OFS_POS_Y = 8;
    localparam int OFS_POS_X = 18;
    localparam int OFS_EN    = 28;
    localparam int OFS_TYPE  = 29;

    typedef struct packed {
        logic       rsvd;
        logic [1:0] obj_type;
        logic       en;
        logic [9:0] pos_x;
        logic [9:0] pos_y;
        logic [1:0] dir;
        logic [2:0] row;
        logic [2:0] col;
    } oam_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

    // start <= pos < start+len, evaluated in 11 bits so spans near 1023 never wrap
    function automatic logic in_span(input logic [9:0] start_v,
                                     input logic [10:0] pos,
                                     input logic [10:0] len);
        logic [10:0] lo;
        lo = {1'b0, start_v};
        return (lo <= pos) && (pos < (lo + len));
    endfunction

endpackage

// File: rtl/oam_line_scanner_if.sv
// Bus between sync generator / OAM RAM (master side) and the line scanner (slave side).
interface oam_line_scanner_if #(parameter int AW = 3);
    logic          video_on;
    logic [9:0]    x;
    logic [9:0]    y;
    logic [AW-1:0] oam_addr;
    logic [31:0]   oam_rdata;
    logic [31:0]   oam_data;
    logic          obj_hit;
    logic          overflow;

    modport master (
        output video_on, x, y, oam_rdata,
        input  oam_addr, oam_data, obj_hit, overflow
    );

    modport slave (
        input  video_on, x, y, oam_rdata,
        output oam_addr, oam_data, obj_hit, overflow
    );
endinterface

// File: rtl/oam_line_cache.sv
// Double-buffered per-line object cache: the scan appends into the back buffer,
// a swap strobe copies back -> front (entries, count, overflow) in one clock.
module oam_line_cache
    import tank_pkg::*;
#(
    parameter  int CACHE_DEPTH = 4,
    localparam int CW = $clog2(CACHE_DEPTH + 1),
    localparam int IW = $clog2(CACHE_DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear_i,
    input  logic                         append_i,
    input  oam_entry_t                   entry_i,
    input  logic                         swap_i,
    output oam_entry_t [CACHE_DEPTH-1:0] front_o,
    output logic [CW-1:0]                front_cnt_o,
    output logic                         front_ovf_o
);

    oam_entry_t [CACHE_DEPTH-1:0] back_q, back_d, front_q, front_d;
    logic [CW-1:0] back_cnt_q, back_cnt_d, front_cnt_q, front_cnt_d;
    logic          back_ovf_q, back_ovf_d, front_ovf_q, front_ovf_d;
    logic          back_full_s;

    assign back_full_s = (back_cnt_q == CW'(CACHE_DEPTH));

    // Back-buffer fill/drop and front-buffer swap
    always_comb begin
        back_d      = back_q;
        back_cnt_d  = back_cnt_q;
        back_ovf_d  = back_ovf_q;
        front_d     = front_q;
        front_cnt_d = front_cnt_q;
        front_ovf_d = front_ovf_q;
        if (clear_i) begin
            back_cnt_d = '0;
            back_ovf_d = 1'b0;
        end else if (append_i) begin
            if (back_full_s) begin
                back_ovf_d = 1'b1;
            end else begin
                back_d[back_cnt_q[IW-1:0]] = entry_i;
                back_cnt_d                 = back_cnt_q + CW'(1);
            end
        end else begin
            back_cnt_d = back_cnt_q;
        end
        if (swap_i) begin
            front_d     = back_q;
            front_cnt_d = back_cnt_q;
            front_ovf_d = back_ovf_q;
        end else begin
            front_cnt_d = front_cnt_q;
        end
    end

    // Cache storage registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            back_q      <= '0;
            back_cnt_q  <= '0;
            back_ovf_q  <= 1'b0;
            front_q     <= '0;
            front_cnt_q <= '0;
            front_ovf_q <= 1'b0;
        end else begin
            back_q      <= back_d;
            back_cnt_q  <= back_cnt_d;
            back_ovf_q  <= back_ovf_d;
            front_q     <= front_d;
            front_cnt_q <= front_cnt_d;
            front_ovf_q <= front_ovf_d;
        end
    end

    assign front_o     = front_q;
    assign front_cnt_o = front_cnt_q;
    assign front_ovf_o = front_ovf_q;

endmodule

// File: rtl/oam_line_scanner.sv
// OAM line scanner: hblank scan of OAM into a per-line cache, then per-pixel object select.
// Build option OAM_SCAN_LAST_WINS_EN: highest cache index wins on overlap instead of lowest.
module oam_line_scanner
    import tank_pkg::*;
#(
    parameter int OAM_DEPTH   = 8,
    parameter int CACHE_DEPTH = 4,
    parameter int TILE_W      = TILE_W_DEF,
    parameter int TILE_H      = TILE_H_DEF,
    parameter int H_VISIBLE   = 640,
    parameter int V_TOTAL     = 525
) (
    input logic                clk,
    input logic                reset,
    oam_line_scanner_if.slave  bus
);

    localparam int AW = $clog2(OAM_DEPTH);
    localparam int SW = $clog2(OAM_DEPTH + 1);
    localparam int CW = $clog2(CACHE_DEPTH + 1);

    scan_state_t   state_q, state_d;
    logic [9:0]    x_prev_q;
    logic [9:0]    tgt_q, tgt_d;
    logic [SW-1:0] cnt_q, cnt_d, nxt_cnt_s;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          hit_q, hit_d;

    logic          hblank_start_s, line_start_s;
    logic          clear_s, append_s, swap_s;
    oam_entry_t    rd_entry_s;

    oam_entry_t [CACHE_DEPTH-1:0] front_s;
    logic [CW-1:0]                front_cnt_s;
    logic                         front_ovf_s;
    logic [CACHE_DEPTH-1:0]       cand_s;
    logic [10:0]                  xn_s;
    logic                         found_s;
    oam_entry_t                   win_s;

    assign hblank_start_s = (bus.x == 10'(H_VISIBLE)) && (x_prev_q != 10'(H_VISIBLE));
    assign line_start_s   = (bus.x == 10'd0) && (x_prev_q != 10'd0);
    assign rd_entry_s     = oam_entry_t'(bus.oam_rdata);
    assign nxt_cnt_s      = cnt_q + SW'(1);

    // FSM and scan datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            x_prev_q <= 10'd0;
            tgt_q    <= 10'd0;
            cnt_q    <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_prev_q <= bus.x;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
        end
    end

    // Next-state logic; triggers outside their state are ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (hblank_start_s) state_d = ST_SCAN; else state_d = ST_IDLE;
            ST_SCAN: if (cnt_q == SW'(OAM_DEPTH)) state_d = ST_DONE; else state_d = ST_SCAN;
            ST_DONE: if (line_start_s) state_d = ST_IDLE; else state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Scan outputs: address walk, target latch, cache strobes
    always_comb begin
        tgt_d    = tgt_q;
        cnt_d    = '0;
        addr_d   = '0;
        clear_s  = 1'b0;
        append_s = 1'b0;
        swap_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hblank_start_s) begin
                    tgt_d   = (bus.y == 10'(V_TOTAL - 1)) ? 10'd0 : bus.y + 10'd1;
                    clear_s = 1'b1;
                end else begin
                    tgt_d = tgt_q;
                end
            end
            ST_SCAN: begin
                // RAM read latency: the word seen at count k belongs to address k-1
                append_s = (cnt_q != '0) && rd_entry_s.en
                           && in_span(rd_entry_s.pos_y, {1'b0, tgt_q}, 11'(TILE_H));
                if (cnt_q == SW'(OAM_DEPTH)) begin
                    cnt_d = '0;
                end else begin
                    cnt_d  = nxt_cnt_s;
                    addr_d = (nxt_cnt_s < SW'(OAM_DEPTH)) ? nxt_cnt_s[AW-1:0] : '0;
                end
            end
            ST_DONE: swap_s = line_start_s;
            default: tgt_d = tgt_q;
        endcase
    end

    oam_line_cache #(.CACHE_DEPTH(CACHE_DEPTH)) u_cache (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (clear_s),
        .append_i    (append_s),
        .entry_i     (rd_entry_s),
        .swap_i      (swap_s),
        .front_o     (front_s),
        .front_cnt_o (front_cnt_s),
        .front_ovf_o (front_ovf_s)
    );

    assign xn_s = {1'b0, bus.x} + 11'd1;

    // Pixel select one pixel ahead so the registered result lines up with x
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        for (int i = 0; i < CACHE_DEPTH; i++) begin
            cand_s[i] = (CW'(i) < front_cnt_s) && in_span(front_s[i].pos_x, xn_s, 11'(TILE_W));
        end
`ifdef OAM_SCAN_LAST_WINS_EN
        for (int i = 0; i < CACHE_DEPTH; i++) begin
`else
        for (int i = CACHE_DEPTH - 1; i >= 0; i--) begin
`endif
            if (cand_s[i]) begin
                found_s = 1'b1;
                win_s   = front_s[i];
            end else begin
                found_s = found_s;
            end
        end
        if (found_s && bus.video_on) begin
            data_d = win_s;
            hit_d  = 1'b1;
        end else begin
            data_d = 32'd0;
            hit_d  = 1'b0;
        end
    end

    // Registered renderer outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= 32'd0;
            hit_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            hit_q  <= hit_d;
        end
    end

    assign bus.oam_addr = addr_q;
    assign bus.oam_data = data_q;
    assign bus.obj_hit  = hit_q;
    assign bus.overflow = front_ovf_s;

endmodule

// File: tb/tb_oam_line_scanner.sv
// Directed bench for oam_line_scanner: OAM RAM model with 1-clk read, hand-computed expectations.
module tb_oam_line_scanner;

    logic        clk;
    logic        reset;
    logic [31:0] oam_mem [8];
    int          pass_cnt;
    int          total_cnt;

    oam_line_scanner_if #(.AW(3)) bus ();

    oam_line_scanner dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.oam_rdata <= oam_mem[bus.oam_addr];

    function automatic logic [31:0] mk(input logic [1:0] t, input logic e,
                                       input logic [9:0] px, input logic [9:0] py,
                                       input logic [1:0] d, input logic [2:0] r,
                                       input logic [2:0] c);
        return {1'b0, t, e, px, py, d, r, c};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 8; i++) oam_mem[i] = 32'd0;
    endtask

    // drive one pixel, clock it, sample 1 time unit after the edge
    task automatic tick(input int nx, input int ny, input logic von);
        bus.x = 10'(nx);
        bus.y = 10'(ny);
        bus.video_on = von;
        @(posedge clk);
        #1;
    endtask

    task automatic do_hblank(input int yl);
        for (int xx = 638; xx <= 655; xx++) tick(xx, yl, 1'b0);
    endtask

    task automatic new_line(input int yl);
        tick(0, yl, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(0, 0, 1'b0);
        tick(1, 0, 1'b0);
        total_cnt++; if (bus.oam_data !== 32'd0) $display("FAIL rst_data got=%h exp=0", bus.oam_data); else pass_cnt++;
        total_cnt++; if (bus.obj_hit !== 1'b0) $display("FAIL rst_hit got=%b exp=0", bus.obj_hit); else pass_cnt++;
        total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL rst_ovf got=%b exp=0", bus.overflow); else pass_cnt++;
        total_cnt++; if (bus.oam_addr !== 3'd0) $display("FAIL rst_addr got=%0d exp=0", bus.oam_addr); else pass_cnt++;
        reset = 1'b0;
        tick(2, 0, 1'b0);
    endtask

    task automatic test_basic_hit();
        logic [31:0] e2;
        clear_mem();
        e2 = mk(2'b01, 1'b1, 10'd100, 10'd50, 2'd1, 3'd2, 3'd3);
        oam_mem[2] = e2;
        do_hblank(49);
        new_line(50);
        tick(98, 50, 1'b1);
        total_cnt++; if (bus.obj_hit !== 1'b0) $display("FAIL basic_x99 hit=%b exp=0", bus.obj_hit); else pass_cnt++;
        tick(99, 50, 1'b1);
        total_cnt++; if (bus.obj_hit !== 1'b1) $display("FAIL basic_x100_hit hit=%b exp=1", bus.obj_hit); else pass_cnt++;
        total_cnt++; if (bus.oam_data !== e2) $display("FAIL basic_x100_data got=%h exp=%h", bus.oam_data, e2); else pass_cnt++;
        tick(130, 50, 1'b1);
        total_cnt++; if (bus.obj_hit !== 1'b1) $display("FAIL basic_x131 hit=%b exp=1", bus.obj_hit); else pass_cnt++;
        tick(131, 50, 1'b1);
        total_cnt++; if (bus.obj_hit !== 1'b0) $display("FAIL basic_x132 hit=%b exp=0", bus.obj_hit); else pass_cnt++;
        total_cnt++; if (bus.oam_data !== 32'd0) $display("FAIL basic_x132_data got=%h exp=0", bus.oam_data); else pass_cnt++;
    endtask

    task automatic test_vertical();
        do_hblank(48); new_line(49);
        tick(109, 49, 1'b1);
        total_cnt++; if (bus.obj_hit !== 1'b0) $display("FAIL vert_line49 hit=%b exp=0", bus.obj_hit); else pass_cnt++;
        do_hblank(80); new_line(81);
        tick(109, 81, 1'b1);
        total_cnt++; if (bus.obj_hit !== 1'b1) $display("FAIL vert_line81 hit=%b exp=1", bus.obj_hit); else pass_cnt++;
        do_hblank(81); new_line(82);
        tick(109, 82, 1'b1);
        total_cnt++; if (bus.obj_hit !== 1'b0) $display("FAIL vert_line82 hit=%b exp=0", bus.obj_hit); else pass_cnt++;
        oam_mem[2] = mk(2'b01, 1'b0, 10'd100, 10'd50, 2'd1, 3'd2, 3'd3);
        do_hblank(49); new_line(50);
        tick(99, 50, 1'b1);
        total_cnt++; if (bus.obj_hit !== 1'b0) $display("FAIL vert_dis_x100 hit=%b exp=0", bus.obj_hit); else pass_cnt++;
        tick(115, 50, 1'b1);
        total_cnt++; if (bus.obj_hit !== 1'b0) $display("FAIL vert_dis_x116 hit=%b exp=0", bus.obj_hit); else pass_cnt++;
    endtask

    task automatic test_overflow();
        clear_mem();
        for (int i = 0; i < 6; i++) oam_mem[i] = mk(2'b00, 1'b1, 10'(10 + 40 * i), 10'd200, 2'(i), 3'(i), 3'd1);
        do_hblank(199); new_line(200);
        total_cnt++; if (bus.overflow !== 1'b1) $display("FAIL ovf_line200 ovf=%b exp=1", bus.overflow); else pass_cnt++;
        tick(9, 200, 1'b1);
        total_cnt++; if (bus.oam_data !== oam_mem[0]) $display("FAIL ovf_obj0 got=%h exp=%h", bus.oam_data, oam_mem[0]); else pass_cnt++;
        tick(129, 200, 1'b1);
        total_cnt++; if (bus.oam_data !== oam_mem[3]) $display("FAIL ovf_obj3 got=%h exp=%h", bus.oam_data, oam_mem[3]); else pass_cnt++;
        tick(169, 200, 1'b1);
        total_cnt++; if (bus.obj_hit !== 1'b0) $display("FAIL ovf_obj4_dropped hit=%b exp=0", bus.obj_hit); else pass_cnt++;
        tick(209, 200, 1'b1);
        total_cnt++; if (bus.obj_hit !== 1'b0) $display("FAIL ovf_obj5_dropped hit=%b exp=0", bus.obj_hit); else pass_cnt++;
    endtask

    task automatic test_reset_mid_scan();
        for (int xx = 638; xx <= 645; xx++) tick(xx, 200, 1'b0);
        total_cnt++; if (bus.oam_addr !== 3'd5) $display("FAIL mid_addr got=%0d exp=5", bus.oam_addr); else pass_cnt++;
        total_cnt++; if (bus.overflow !== 1'b1) $display("FAIL mid_ovf_pre got=%b exp=1", bus.overflow); else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++; if (bus.oam_addr !== 3'd0) $display("FAIL mid_rst_addr got=%0d exp=0", bus.oam_addr); else pass_cnt++;
        total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL mid_rst_ovf got=%b exp=0", bus.overflow); else pass_cnt++;
        total_cnt++; if (bus.obj_hit !== 1'b0) $display("FAIL mid_rst_hit got=%b exp=0", bus.obj_hit); else pass_cnt++;
        total_cnt++; if (bus.oam_data !== 32'd0) $display("FAIL mid_rst_data got=%h exp=0", bus.oam_data); else pass_cnt++;
        #1 reset = 1'b0;
        for (int xx = 646; xx <= 655; xx++) tick(xx, 200, 1'b0);
        do_hblank(200); new_line(201);
        total_cnt++; if (bus.overflow !== 1'b1) $display("FAIL mid_line201_ovf got=%b exp=1", bus.overflow); else pass_cnt++;
        tick(89, 201, 1'b1);
        total_cnt++; if (bus.oam_data !== oam_mem[2]) $display("FAIL mid_line201_obj2 got=%h exp=%h", bus.oam_data, oam_mem[2]); else pass_cnt++;
        do_hblank(239); new_line(240);
        total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL ovf_line240 ovf=%b exp=0", bus.overflow); else pass_cnt++;
        tick(9, 240, 1'b1);
        total_cnt++; if (bus.obj_hit !== 1'b0) $display("FAIL ovf_line240_hit hit=%b exp=0", bus.obj_hit); else pass_cnt++;
    endtask

    task automatic test_overlap();
        logic [31:0] e1, e4, ew;
        clear_mem();
        e1 = mk(2'b00, 1'b1, 10'd290, 10'd5, 2'd2, 3'd1, 3'd4);
        e4 = mk(2'b01, 1'b1, 10'd280, 10'd5, 2'd3, 3'd6, 3'd7);
        oam_mem[1] = e1;
        oam_mem[4] = e4;
`ifdef OAM_SCAN_LAST_WINS_EN
        ew = e4;
`else
        ew = e1;
`endif
        do_hblank(9); new_line(10);
        tick(299, 10, 1'b1);
        total_cnt++; if (bus.oam_data !== ew) $display("FAIL overlap_x300 got=%h exp=%h", bus.oam_data, ew); else pass_cnt++;
        tick(284, 10, 1'b1);
        total_cnt++; if (bus.oam_data !== e4) $display("FAIL overlap_x285 got=%h exp=%h", bus.oam_data, e4); else pass_cnt++;
        tick(314, 10, 1'b1);
        total_cnt++; if (bus.oam_data !== e1) $display("FAIL overlap_x315 got=%h exp=%h", bus.oam_data, e1); else pass_cnt++;
        tick(299, 10, 1'b0);
        total_cnt++; if (bus.obj_hit !== 1'b0) $display("FAIL overlap_video_off hit=%b exp=0", bus.obj_hit); else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [31:0] e0, e3;
        clear_mem();
        e0 = mk(2'b00, 1'b1, 10'd100, 10'd0, 2'd0, 3'd0, 3'd0);
        e3 = mk(2'b01, 1'b1, 10'd1000, 10'd0, 2'd1, 3'd5, 3'd2);
        oam_mem[0] = e0;
        oam_mem[3] = e3;
        do_hblank(524); new_line(0);
        tick(99, 0, 1'b1);
        total_cnt++; if (bus.oam_data !== e0) $display("FAIL wrap_line0_x100 got=%h exp=%h", bus.oam_data, e0); else pass_cnt++;
        tick(4, 0, 1'b1);
        total_cnt++; if (bus.obj_hit !== 1'b0) $display("FAIL wrap_x5 hit=%b exp=0", bus.obj_hit); else pass_cnt++;
        tick(30, 0, 1'b1);
        total_cnt++; if (bus.obj_hit !== 1'b0) $display("FAIL wrap_x31 hit=%b exp=0", bus.obj_hit); else pass_cnt++;
        tick(999, 0, 1'b1);
        total_cnt++; if (bus.oam_data !== e3) $display("FAIL wrap_x1000 got=%h exp=%h", bus.oam_data, e3); else pass_cnt++;
        tick(1022, 0, 1'b1);
        total_cnt++; if (bus.oam_data !== e3) $display("FAIL wrap_x1023 got=%h exp=%h", bus.oam_data, e3); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        reset = 1'b1;
        bus.x = 10'd0;
        bus.y = 10'd0;
        bus.video_on = 1'b0;
        clear_mem();
        test_reset();
        test_basic_hit();
        test_vertical();
        test_overflow();
        test_reset_mid_scan();
        test_overlap();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
